// File: rtl/rv32_cpu_cp_mul_ser_if.sv
// Co-processor issue/result bundle for the serial multiplier.
// The CPU side drives the request fields; the multiplier returns a
// result that is zero whenever the valid strobe is low.
`timescale 1ns/1ps

interface rv32_cpu_cp_mul_ser_if #(
    parameter int XLEN = 32
);
    logic              i_start;
    logic              i_cpu_trap;
    logic [2:0]        i_mul_op;
    logic [XLEN-1:0]   i_rs1;
    logic [XLEN-1:0]   i_rs2;
    logic [XLEN-1:0]   o_res;
    logic              o_valid;

    // CPU issue port view
    modport master (
        output i_start,
        output i_cpu_trap,
        output i_mul_op,
        output i_rs1,
        output i_rs2,
        input  o_res,
        input  o_valid
    );

    // Multiplier view
    modport slave (
        input  i_start,
        input  i_cpu_trap,
        input  i_mul_op,
        input  i_rs1,
        input  i_rs2,
        output o_res,
        output o_valid
    );
endinterface

// File: rtl/rv32_cpu_cp_mul_ser.sv
// Serial shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One multiplier bit is consumed per cycle: the low half of the product
// register initially holds rs1 and is shifted out LSB first while the
// partial sum accumulates in the high half. A signed rs1 has its sign bit
// weighted negatively, so the final iteration subtracts instead of adds.
// Outputs are registered and are zero outside the single DONE cycle, so
// this unit can be OR-ed with the divider onto a shared result bus.
`timescale 1ns/1ps

module rv32_cpu_cp_mul_ser #(
    parameter int XLEN = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    rv32_cpu_cp_mul_ser_if.slave bus
);

    localparam int PW = 2 * XLEN;   // product register width
    localparam int AW = XLEN + 1;   // adder width (one guard/sign bit)

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [PW-1:0]     prod_r;
    logic [2:0]        op_r;
    logic [4:0]        cnt_r;
    logic [XLEN-1:0]   rs2_r;
    logic              rs1_signed_r;
    logic              rs2_signed_r;
    logic              valid_r;
    logic [XLEN-1:0]   res_r;

    logic [AW-1:0]     addend_s;
    logic [AW-1:0]     hi_ext_s;
    logic [AW-1:0]     sum_s;
    logic              last_s;
    logic              finish_s;
    logic              step_s;
    logic [XLEN-1:0]   res_nxt_s;

    // Shift-add datapath: one 33-bit add (or subtract on the final signed-rs1 step)
    always_comb begin
        addend_s = {AW{1'b0}};
        hi_ext_s = {AW{1'b0}};
        sum_s    = {AW{1'b0}};
        last_s   = (cnt_r == 5'd0);
        if (prod_r[0]) begin
            addend_s = {rs2_signed_r & rs2_r[XLEN-1], rs2_r};
        end else begin
            addend_s = {AW{1'b0}};
        end
        hi_ext_s = {prod_r[PW-1] & rs2_signed_r, prod_r[PW-1:XLEN]};
        if (last_s && rs1_signed_r) begin
            sum_s = hi_ext_s - addend_s;
        end else begin
            sum_s = hi_ext_s + addend_s;
        end
    end

    // Control decodes: iteration enable and the BUSY-to-DONE transition
    always_comb begin
        step_s   = 1'b0;
        finish_s = 1'b0;
        if (state_r == ST_BUSY && !bus.i_cpu_trap) begin
            step_s   = 1'b1;
            finish_s = last_s;
        end else begin
            step_s   = 1'b0;
            finish_s = 1'b0;
        end
    end

    // Result selection from the product value being written on the final step
    always_comb begin
        res_nxt_s = {XLEN{1'b0}};
        if (!finish_s) begin
            res_nxt_s = {XLEN{1'b0}};
        end else if (op_r == OP_MUL) begin
            res_nxt_s = {sum_s[0], prod_r[XLEN-1:1]};
        end else begin
            res_nxt_s = sum_s[AW-1:1];
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a trap aborts BUSY, DONE always returns to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.i_cpu_trap) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture on start and per-cycle product/counter update
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            prod_r       <= {PW{1'b0}};
            op_r         <= 3'b000;
            cnt_r        <= 5'd0;
            rs2_r        <= {XLEN{1'b0}};
            rs1_signed_r <= 1'b0;
            rs2_signed_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        op_r         <= bus.i_mul_op;
                        rs1_signed_r <= (bus.i_mul_op == OP_MULH) ||
                                        (bus.i_mul_op == OP_MULHSU);
                        rs2_signed_r <= (bus.i_mul_op == OP_MULH);
                        rs2_r        <= bus.i_rs2;
                        prod_r       <= {{XLEN{1'b0}}, bus.i_rs1};
                        cnt_r        <= 5'd31;
                    end else begin
                        prod_r <= prod_r;
                    end
                end
                ST_BUSY: begin
                    if (step_s) begin
                        prod_r <= {sum_s, prod_r[XLEN-1:1]};
                        cnt_r  <= cnt_r - 5'd1;
                    end else begin
                        prod_r <= prod_r;
                    end
                end
                default: begin
                    prod_r <= prod_r;
                end
            endcase
        end
    end

    // Registered result strobe and bus value, high only for the DONE cycle
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_r <= 1'b0;
            res_r   <= {XLEN{1'b0}};
        end else begin
            valid_r <= finish_s;
            res_r   <= res_nxt_s;
        end
    end

    assign bus.o_valid = valid_r;
    assign bus.o_res   = res_r;

endmodule
